// File: rtl/instr_prefetch_unit.sv
// Instruction prefetch unit: byte-cell ROM feeding a FIFO_DEPTH-entry queue of {instr, pc+4}.
// Optional INSTR_ALIGN_CHECK_EN flags misaligned branch targets and word-aligns them.
module instr_prefetch_unit #(
    parameter int unsigned WORD_LEN   = 8,
    parameter int unsigned MEM_SIZE   = 1024,
    parameter int unsigned INST_LEN   = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [INST_LEN-1:0] RESET_PC = '0,
    parameter string INIT_FILE = "instructions.mem"
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                branch_taken,
    input  logic [INST_LEN-1:0] branch_addr,
    input  logic                ready,
    output logic                valid,
    output logic [INST_LEN-1:0] instr,
    output logic [INST_LEN-1:0] pc_plus4,
    output logic                misalign
);

    localparam int unsigned AW = $clog2(MEM_SIZE);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0]       FULL = CW'(FIFO_DEPTH);
    localparam logic [INST_LEN-1:0] STEP = INST_LEN'(4);
    localparam logic [31:0]         NOP  = 32'hE000_0000;

    logic [WORD_LEN-1:0] mem [MEM_SIZE];

    // ROM image: every unset word reads as NOP
    initial begin
        for (int unsigned i = 0; i < MEM_SIZE; i++)
            mem[i] = WORD_LEN'(NOP >> (8 * (3 - (i % 4))));
    end

    logic [INST_LEN-1:0] fetch_pc;
    logic [INST_LEN-1:0] branch_target;
    logic [CW-1:0]       count;
    logic [PW-1:0]       rd_ptr;
    logic [PW-1:0]       wr_ptr;
    logic                started;
    logic                push;
    logic                pop;
    logic [AW-1:0]       a0;
    logic [INST_LEN-1:0] rd_word;

    logic [INST_LEN-1:0] q_instr [FIFO_DEPTH];
    logic [INST_LEN-1:0] q_pc4   [FIFO_DEPTH];

    assign a0      = fetch_pc[AW-1:0];
    assign rd_word = INST_LEN'({mem[a0], mem[a0 + AW'(1)], mem[a0 + AW'(2)], mem[a0 + AW'(3)]});

    assign valid    = (count != '0);
    assign instr    = q_instr[rd_ptr];
    assign pc_plus4 = q_pc4[rd_ptr];
    assign pop      = valid && ready;
    // started holds off the first fetch one cycle so valid rises on the 2nd edge after reset
    assign push     = started && ((count < FULL) || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            started  <= 1'b0;
        end else if (branch_taken) begin
            fetch_pc <= branch_target;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            started  <= 1'b1;
        end else begin
            started <= 1'b1;
            if (push) begin
                wr_ptr   <= wr_ptr + PW'(1);
                fetch_pc <= fetch_pc + STEP;
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !branch_taken) begin
            q_instr[wr_ptr] <= rd_word;
            q_pc4[wr_ptr]   <= fetch_pc + STEP;
        end
    end

`ifdef INSTR_ALIGN_CHECK_EN
    assign branch_target = {branch_addr[INST_LEN-1:2], 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            misalign <= 1'b0;
        else if (branch_taken)
            misalign <= |branch_addr[1:0];
    end
`else
    assign branch_target = branch_addr;
    assign misalign      = 1'b0;
`endif

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Directed bench for instr_prefetch_unit: vector table plus hand-written wrap, reset and alignment sequences.
module tb_instr_prefetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        ready;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        misalign;

    int n_checks = 0;
    int n_fail   = 0;

    instr_prefetch_unit #(
        .WORD_LEN  (8),
        .MEM_SIZE  (1024),
        .INST_LEN  (32),
        .FIFO_DEPTH(4),
        .RESET_PC  (32'h0),
        .INIT_FILE ("")
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .branch_taken(branch_taken),
        .branch_addr (branch_addr),
        .ready       (ready),
        .valid       (valid),
        .instr       (instr),
        .pc_plus4    (pc_plus4),
        .misalign    (misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        br;
        logic [31:0] baddr;
        logic        rdy;
        logic        exp_valid;
        logic        chk_data;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc4;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic b, input logic [31:0] a, input logic rd,
                       input logic ev, input logic cd, input logic [31:0] ei, input logic [31:0] ep);
        vec_t v;
        v.rst = r; v.br = b; v.baddr = a; v.rdy = rd;
        v.exp_valid = ev; v.chk_data = cd; v.exp_instr = ei; v.exp_pc4 = ep;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load_word(input int unsigned a, input logic [31:0] w);
        dut.mem[a]     = w[31:24];
        dut.mem[a + 1] = w[23:16];
        dut.mem[a + 2] = w[15:8];
        dut.mem[a + 3] = w[7:0];
    endtask

    task automatic cyc(input logic b, input logic [31:0] a, input logic r);
        branch_taken = b;
        branch_addr  = a;
        ready        = r;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_head(input string name, input logic [31:0] ei, input logic [31:0] ep);
        chk({name, ".valid"}, 32'(valid), 32'd1);
        chk({name, ".instr"}, instr, ei);
        chk({name, ".pc4"}, pc_plus4, ep);
    endtask

    logic [31:0] exp_mis_instr;
    logic [31:0] exp_mis_pc4;
    logic        exp_mis;

    initial begin
        rst = 1'b1; branch_taken = 1'b0; branch_addr = '0; ready = 1'b0;
        #1;
        load_word(32'h000, 32'hE3A00014);
        load_word(32'h004, 32'hE3A01A01);
        load_word(32'h008, 32'h11223344);
        load_word(32'h020, 32'h55667788);
        load_word(32'h024, 32'h99AABBCC);
        load_word(32'h094, 32'h12345678);
        load_word(32'h3FC, 32'hAABBCCDD);
        @(negedge clk);
        @(negedge clk);
        chk("reset.valid", 32'(valid), 32'd0);
        chk("reset.misalign", 32'(misalign), 32'd0);

        // rst br baddr rdy | valid chk instr pc4
        add(0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 1, 1, 1, 32'hE3A00014, 32'h4);
        add(0, 0, 0, 1, 1, 1, 32'hE3A01A01, 32'h8);
        add(1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++)
            add(0, 0, 0, 0, 1, 1, 32'hE3A00014, 32'h4);
        add(0, 0, 0, 1, 1, 1, 32'hE3A01A01, 32'h8);
        add(0, 0, 0, 1, 1, 1, 32'h11223344, 32'hC);
        add(0, 0, 0, 1, 1, 1, 32'hE0000000, 32'h10);
        add(0, 0, 0, 1, 1, 1, 32'hE0000000, 32'h14);
        add(0, 1, 32'h94, 1, 0, 0, 0, 0);
        add(0, 0, 0, 1, 1, 1, 32'h12345678, 32'h98);
        add(0, 0, 0, 0, 1, 1, 32'h12345678, 32'h98);

        foreach (vecs[i]) begin
            rst          = vecs[i].rst;
            branch_taken = vecs[i].br;
            branch_addr  = vecs[i].baddr;
            ready        = vecs[i].rdy;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d.valid", i), 32'(valid), 32'(vecs[i].exp_valid));
            if (vecs[i].chk_data) begin
                chk($sformatf("v%0d.instr", i), instr, vecs[i].exp_instr);
                chk($sformatf("v%0d.pc4", i), pc_plus4, vecs[i].exp_pc4);
            end
        end

        // memory index wraps at MEM_SIZE, pc_plus4 does not
        cyc(1, 32'h3FC, 1);
        chk("wrap.flush", 32'(valid), 32'd0);
        cyc(0, 0, 1);
        chk_head("wrap.last", 32'hAABBCCDD, 32'h400);
        cyc(0, 0, 1);
        chk_head("wrap.idx0", 32'hE3A00014, 32'h404);

        // full-width pc wrap at 2^32
        cyc(1, 32'hFFFF_FFFC, 1);
        cyc(0, 0, 1);
        chk_head("pcwrap.top", 32'hAABBCCDD, 32'h0);
        cyc(0, 0, 1);
        chk_head("pcwrap.zero", 32'hE3A00014, 32'h4);

`ifndef INSTR_ALIGN_CHECK_EN
        // byte cells a+1..a+3 wrap individually
        cyc(1, 32'h3FE, 1);
        cyc(0, 0, 1);
        chk_head("bytewrap", 32'hCCDDE3A0, 32'h402);
`endif

`ifdef INSTR_ALIGN_CHECK_EN
        exp_mis = 1'b1; exp_mis_instr = 32'h55667788; exp_mis_pc4 = 32'h24;
`else
        exp_mis = 1'b0; exp_mis_instr = 32'h778899AA; exp_mis_pc4 = 32'h26;
`endif
        cyc(1, 32'h22, 1);
        chk("mis.flag", 32'(misalign), 32'(exp_mis));
        chk("mis.flush", 32'(valid), 32'd0);
        cyc(0, 0, 1);
        chk_head("mis.fetch", exp_mis_instr, exp_mis_pc4);
        chk("mis.hold", 32'(misalign), 32'(exp_mis));
        cyc(1, 32'h40, 1);
        chk("mis.clear", 32'(misalign), 32'd0);

        // async reset with three entries queued; rst must also beat a concurrent branch
        cyc(1, 32'h0, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk_head("arst.pre", 32'hE3A00014, 32'h4);
        #2;
        rst = 1'b1;
        #1;
        chk("arst.valid", 32'(valid), 32'd0);
        chk("arst.misalign", 32'(misalign), 32'd0);
        branch_taken = 1'b1;
        branch_addr  = 32'h94;
        @(negedge clk);
        branch_taken = 1'b0;
        rst = 1'b0;
        cyc(0, 0, 1);
        chk("arst.rel1", 32'(valid), 32'd0);
        cyc(0, 0, 1);
        chk_head("arst.restart", 32'hE3A00014, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_prefetch_unit.md
INSTR_PREFETCH_UNIT -- requirements
Module: instr_prefetch_unit

Interface
REQ-001 SHALL have parameter WORD_LEN, default 8: bits per memory byte cell.
REQ-002 SHALL have parameter MEM_SIZE, default 1024: memory size in byte cells; power of 2, at least 16.
REQ-003 SHALL have parameter INST_LEN, default 32: instruction and address width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4: prefetch queue entries; power of 2, at least 2.
REQ-005 SHALL have parameter RESET_PC, default 0: first fetch address after reset.
REQ-006 SHALL have parameter INIT_FILE, default "instructions.mem": hex image loaded into memory at elaboration.
REQ-007 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-008 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-009 SHALL have port branch_taken, input, 1 bit: redirect fetch and flush the queue.
REQ-010 SHALL have port branch_addr, input, INST_LEN bits: redirect byte address.
REQ-011 SHALL have port ready, input, 1 bit: the consumer accepts the head entry.
REQ-012 SHALL have port valid, output, 1 bit: the head entry is present.
REQ-013 SHALL have port instr, output, INST_LEN bits: head instruction.
REQ-014 SHALL have port pc_plus4, output, INST_LEN bits: head address + 4.
REQ-015 SHALL have port misalign, output, 1 bit: misaligned branch flag (see Configuration).

Function
REQ-016 SHALL store instructions big-endian as 4 consecutive byte cells: instr = {mem[a], mem[a+1], mem[a+2], mem[a+3]}.
REQ-017 SHALL fill every cell not set by INIT_FILE so that each unset word reads NOP 32'hE0000000.
REQ-018 SHALL compute the memory index as fetch_pc mod MEM_SIZE, with byte indices a+1..a+3 also wrapping modulo MEM_SIZE.
REQ-019 SHALL define push = (count < FIFO_DEPTH) or pop, and pop = valid and ready.
REQ-020 SHALL, on push, do all of the following on the same edge: read memory combinationally at fetch_pc, enqueue {instr, fetch_pc+4}, and advance fetch_pc by 4.
REQ-021 SHALL let push and pop occur on the same edge; count is unchanged in that case, including when the queue is full.
REQ-022 SHALL hold valid = (count != 0); instr and pc_plus4 SHALL come from the head entry and are don't-care while valid=0.
REQ-023 SHALL hold the head entry and its outputs stable while valid=1 and ready=0.
REQ-024 SHALL, on branch_taken, give branch priority over push and pop: count=0, read/write pointers to 0, fetch_pc=branch_addr.
REQ-025 SHALL drive valid low on the cycle after a branch; the first push from branch_addr SHALL make valid=1 one cycle later.
REQ-026 SHALL give fetch_pc and pc_plus4 a full INST_LEN width; they wrap at 2^INST_LEN, not at MEM_SIZE.
REQ-027 SHALL make valid first assert at the second rising edge after rst deasserts, with the RESET_PC instruction at the head.

Reset
REQ-028 SHALL, while rst=1, immediately set fetch_pc=RESET_PC, count=0, both pointers=0, valid=0 and misalign=0.
REQ-029 SHALL, on a reset asserted mid-operation, discard the queue contents; memory contents SHALL NOT be modified.
REQ-030 SHALL let rst override branch_taken.

Configuration
REQ-031 SHALL, when macro INSTR_ALIGN_CHECK_EN is defined, register misalign=1 on the edge where branch_taken=1 and branch_addr[1:0]!=0, and clear misalign on the next branch with aligned branch_addr.
REQ-032 SHALL, when INSTR_ALIGN_CHECK_EN is defined and a misaligned branch is taken, use {branch_addr[INST_LEN-1:2], 2'b00} as the new fetch_pc.
REQ-033 SHALL, when INSTR_ALIGN_CHECK_EN is undefined, tie misalign to 0 and use branch_addr unmodified as fetch_pc.

Verification
REQ-034 SHALL cover: INIT_FILE word0=E3A00014, word1=E3A01A01, ready=1 after reset -> valid at 2nd edge, instr=E3A00014 with pc_plus4=4, then E3A01A01 with pc_plus4=8.
REQ-035 SHALL cover: ready=0 for 10 cycles -> count saturates at 4, fetch_pc=16, head stays E3A00014; then ready=1 -> instructions streamed back-to-back with pc_plus4 4,8,12,16,20.
REQ-036 SHALL cover: branch_taken=1 with branch_addr=0x94 while the queue is full -> valid=0 the next cycle, then instr=mem word at 0x94 with pc_plus4=0x98.
REQ-037 SHALL cover: fetch reaching 0x3FC with MEM_SIZE=1024 -> next fetch returns the word at index 0 with pc_plus4=0x404; an unset word returns E0000000.
REQ-038 SHALL cover: rst asserted asynchronously mid-stream with count=3 -> valid=0 immediately; after release, restart from RESET_PC.
REQ-039 SHALL cover, with INSTR_ALIGN_CHECK_EN defined: branch_addr=0x22 -> misalign=1 and fetch from 0x20; without the macro, misalign stays 0.
